inst_mem_banked: RTL and testbench

- Parametrised, writable successor to the fixed instruction ROM: NUM_BANKS independent program banks, each DEPTH=2^ADDR_W words of WIDTH bits.
- Registered fetch port feeds the core's instruction decode.
- A valid/ready loader port streams a program into one bank at run time, so programs no longer have to be hard-coded.
- Unloaded, busy or out-of-range locations read as FILL, the same default the old ROM returned.

---
 rtl/inst_mem_banked.sv | 106 ++++++++++
 tb/tb_inst_mem_banked.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_banked.sv
// inst_mem_banked: multi-bank instruction memory with a registered fetch port and a valid/ready program loader
module inst_mem_banked #(
    parameter int WIDTH = 8,
    parameter int ADDR_W = 8,
    parameter int NUM_BANKS = 2,
    parameter logic [WIDTH-1:0] FILL = WIDTH'(8'hFF),
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              fetch_en_i,
    input  logic [BANK_W-1:0] bank_sel_i,
    input  logic [ADDR_W-1:0] address_i,
    output logic [WIDTH-1:0]  instruction_o,
    output logic              valid_o,
    input  logic              load_start_i,
    input  logic [BANK_W-1:0] load_bank_i,
    input  logic              load_valid_i,
    input  logic [WIDTH-1:0]  load_data_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    output logic              busy_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            r_state, w_next;
    logic [BANK_W-1:0] r_bank;
    logic [ADDR_W:0]   r_wcnt;
    logic [ADDR_W:0]   r_len [NUM_BANKS];
    logic [WIDTH-1:0]  r_mem [NUM_BANKS][DEPTH];
    logic [WIDTH-1:0]  r_instr;
    logic              r_valid;

    logic              w_start, w_hs, w_bank_ok, w_hit;
    logic [BANK_W-1:0] w_fbank;

    assign w_start   = load_start_i && (int'(load_bank_i) < NUM_BANKS);
    assign w_hs      = load_valid_i && (r_state == LOAD);
    assign w_bank_ok = int'(bank_sel_i) < NUM_BANKS;
    assign w_fbank   = w_bank_ok ? bank_sel_i : '0;
    // A bank being (re)loaded is hidden so a partial program is never fetched
    assign w_hit     = w_bank_ok && ({1'b0, address_i} < r_len[w_fbank])
                       && !((r_state != IDLE) && (r_bank == bank_sel_i));

    assign instruction_o = r_instr;
    assign valid_o       = r_valid;

    // Loader FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next state and state-decoded loader outputs
    always_comb begin
        w_next       = IDLE;
        load_ready_o = 1'b0;
        busy_o       = 1'b0;
        load_done_o  = 1'b0;
        if (r_state == IDLE)
            w_next = w_start ? LOAD : IDLE;
        else if (r_state == LOAD) begin
            w_next       = (w_hs && (load_last_i || r_wcnt == LAST_CNT)) ? DONE : LOAD;
            load_ready_o = 1'b1;
            busy_o       = 1'b1;
        end else
            load_done_o  = 1'b1;
    end

    // Target bank, write counter and per-bank program lengths
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_bank <= '0;
            r_wcnt <= '0;
            for (int b = 0; b < NUM_BANKS; b++) r_len[b] <= '0;
        end else begin
            if (r_state == IDLE && w_start) begin
                r_bank              <= load_bank_i;
                r_wcnt              <= '0;
                r_len[load_bank_i]  <= '0;
            end
            if (w_hs) r_wcnt <= r_wcnt + 1'b1;
            if (r_state == DONE) r_len[r_bank] <= r_wcnt;
        end
    end

    // Program storage, written one word per loader handshake
    always_ff @(posedge clk_i) begin
        if (w_hs) r_mem[r_bank][r_wcnt[ADDR_W-1:0]] <= load_data_i;
    end

    // Registered fetch; invalid locations return FILL
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_instr <= FILL;
            r_valid <= 1'b0;
        end else begin
            r_valid <= fetch_en_i;
            if (fetch_en_i) r_instr <= w_hit ? r_mem[w_fbank][address_i] : FILL;
        end
    end
endmodule

// File: tb/tb_inst_mem_banked.sv
// tb_inst_mem_banked: scoreboard bench for inst_mem_banked (default build plus a small 3-bank build)
module tb_inst_mem_banked;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_fe = 0, a_bs = 0, a_ls = 0, a_lb = 0, a_lv = 0, a_ll = 0;
    logic [7:0] a_ad = 0, a_ld = 0;
    logic [7:0] a_ins;
    logic       a_vo, a_rdy, a_done, a_busy;

    logic       b_fe = 0, b_ls = 0, b_lv = 0, b_ll = 0;
    logic [1:0] b_bs = 0, b_ad = 0, b_lb = 0;
    logic [7:0] b_ld = 0;
    logic [7:0] b_ins;
    logic       b_vo, b_rdy, b_done, b_busy;

    int n_chk = 0, n_pass = 0;
    logic [7:0] q[$];
    logic f_s;

    inst_mem_banked dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .fetch_en_i(a_fe), .bank_sel_i(a_bs), .address_i(a_ad),
        .instruction_o(a_ins), .valid_o(a_vo), .load_start_i(a_ls), .load_bank_i(a_lb),
        .load_valid_i(a_lv), .load_data_i(a_ld), .load_last_i(a_ll), .load_ready_o(a_rdy),
        .load_done_o(a_done), .busy_o(a_busy)
    );

    inst_mem_banked #(.ADDR_W(2), .NUM_BANKS(3)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .fetch_en_i(b_fe), .bank_sel_i(b_bs), .address_i(b_ad),
        .instruction_o(b_ins), .valid_o(b_vo), .load_start_i(b_ls), .load_bank_i(b_lb),
        .load_valid_i(b_lv), .load_data_i(b_ld), .load_last_i(b_ll), .load_ready_o(b_rdy),
        .load_done_o(b_done), .busy_o(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fetch_a(input logic bank, input logic [7:0] addr, input logic [7:0] exp);
        a_fe = 1; a_bs = bank; a_ad = addr; q.push_back(exp);
        tick();
        a_fe = 0;
    endtask

    task automatic fetch_b(input logic [1:0] bank, input logic [1:0] addr, input logic [7:0] exp);
        b_fe = 1; b_bs = bank; b_ad = addr;
        tick();
        b_fe = 0;
        chk("b_valid", b_vo, 1);
        chk("b_instr", b_ins, exp);
    endtask

    // Scoreboard monitor for instance A: every sampled fetch must yield one popped expectation
    always @(posedge clk) begin
        f_s = a_fe && rst_n;
        #1;
        if (rst_n) begin
            chk("a_valid", a_vo, f_s);
            if (f_s) begin
                if (q.size() != 0) chk("a_instr", a_ins, q.pop_front());
                else chk("a_queue_underflow", 1, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int acc, nrdy, dn;
        repeat (2) tick();
        chk("rst_instr", a_ins, 8'hFF);
        chk("rst_valid", a_vo, 0);
        chk("rst_ready", a_rdy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_busy", a_busy, 0);
        rst_n = 1;
        tick();

        fetch_a(0, 8'h00, 8'hFF);
        chk("idle_ready", a_rdy, 0);

        a_ls = 1; a_lb = 0;
        tick();
        a_ls = 0;
        chk("load_busy", a_busy, 1);
        chk("load_ready", a_rdy, 1);
        a_lv = 1; a_ld = 8'hC0; a_ll = 0; tick();
        chk("no_early_done", a_done, 0);
        a_ld = 8'hC2; tick();
        a_ld = 8'h11; a_ll = 1; tick();
        a_lv = 0; a_ll = 0;
        chk("done_pulse", a_done, 1);
        chk("done_busy", a_busy, 0);
        chk("done_ready", a_rdy, 0);
        tick();
        chk("done_clear", a_done, 0);
        fetch_a(0, 8'd0, 8'hC0);
        fetch_a(0, 8'd1, 8'hC2);
        fetch_a(0, 8'd2, 8'h11);
        fetch_a(0, 8'd3, 8'hFF);

        a_ls = 1; a_lb = 1;
        a_fe = 1; a_bs = 0; a_ad = 8'd1; q.push_back(8'hC2);
        tick();
        a_ls = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) chk("b1_done_pulse", a_done, 1);
            a_lv = (i % 2 == 0) && (i < 6);
            a_ld = 8'hA0 + 8'(i / 2);
            a_ll = (i == 4);
            a_fe = 1;
            if (i % 2 == 0) begin a_bs = 0; a_ad = 8'd1; q.push_back(8'hC2); end
            else begin a_bs = 1; a_ad = 8'd0; q.push_back(8'hFF); end
            tick();
        end
        a_fe = 0; a_lv = 0; a_ll = 0;
        fetch_a(1, 8'd0, 8'hA0);
        fetch_a(1, 8'd1, 8'hA1);
        fetch_a(1, 8'd2, 8'hA2);
        fetch_a(1, 8'd3, 8'hFF);
        fetch_a(0, 8'd1, 8'hC2);
        fetch_a(1, 8'd2, 8'hA2);
        tick();
        chk("hold_instr", a_ins, 8'hA2);

        a_ls = 1; a_lb = 0; tick();
        a_ls = 0;
        a_lv = 1; a_ld = 8'h77; tick();
        a_ld = 8'h78; tick();
        a_lv = 0;
        #2 rst_n = 0;
        #1;
        chk("midrst_instr", a_ins, 8'hFF);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_ready", a_rdy, 0);
        chk("midrst_done", a_done, 0);
        tick();
        rst_n = 1;
        tick();
        chk("postrst_done", a_done, 0);
        fetch_a(0, 8'd0, 8'hFF);
        fetch_a(1, 8'd0, 8'hFF);

        b_ls = 1; b_lb = 2; tick();
        b_ls = 0;
        acc = 0; nrdy = 0; dn = 0;
        for (int j = 0; j < 6; j++) begin
            b_lv = 1; b_ld = 8'h50 + 8'(j);
            if (b_rdy) acc++; else nrdy++;
            tick();
            if (b_done) dn++;
        end
        b_lv = 0;
        chk("auto_accepted", acc, 4);
        chk("auto_not_ready", nrdy, 2);
        chk("auto_done_count", dn, 1);
        fetch_b(2, 2'd3, 8'h53);
        fetch_b(2, 2'd0, 8'h50);

        b_ls = 1; b_lb = 3; tick();
        b_ls = 0;
        chk("oor_busy", b_busy, 0);
        chk("oor_ready", b_rdy, 0);
        tick();
        chk("oor_done", b_done, 0);
        fetch_b(3, 2'd0, 8'hFF);
        tick();
        chk("b_valid_low", b_vo, 0);
        chk("b_hold", b_ins, 8'hFF);

        repeat (2) tick();
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
